tx_cfg_sequencer: RTL and testbench

- AXI4-Lite master that programs the TX block's slave register bank from a configuration vector on a single start pulse.
- After the writes, optionally reads every register back and compares it with the value written.
- Sits between the system control logic and the TX block's S00_AXI port, so software or firmware does not have to drive individual register transactions.
- Reports completion, the first error, and the register index that caused it.

---
 rtl/tx_cfg_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_tx_cfg_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_cfg_sequencer.sv
// AXI4-Lite master that writes a block of configuration registers from a
// packed vector on a start pulse, optionally reads them back and compares.
module tx_cfg_sequencer #(
  parameter int NUM_REGS       = 4,
  parameter int ADDR_WIDTH     = 4,
  parameter int BASE_ADDR      = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     start,
  input  logic                     verify_en,
  input  logic [32*NUM_REGS-1:0]   cfg_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [1:0]               err_code,
  output logic [3:0]               err_index,
  output logic [ADDR_WIDTH-1:0]    M_AXI_AWADDR,
  output logic [2:0]               M_AXI_AWPROT,
  output logic                     M_AXI_AWVALID,
  input  logic                     M_AXI_AWREADY,
  output logic [31:0]              M_AXI_WDATA,
  output logic [3:0]               M_AXI_WSTRB,
  output logic                     M_AXI_WVALID,
  input  logic                     M_AXI_WREADY,
  input  logic [1:0]               M_AXI_BRESP,
  input  logic                     M_AXI_BVALID,
  output logic                     M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]    M_AXI_ARADDR,
  output logic [2:0]               M_AXI_ARPROT,
  output logic                     M_AXI_ARVALID,
  input  logic                     M_AXI_ARREADY,
  input  logic [31:0]              M_AXI_RDATA,
  input  logic [1:0]               M_AXI_RRESP,
  input  logic                     M_AXI_RVALID,
  output logic                     M_AXI_RREADY
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    LAST_IDX = 4'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    FINISH
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  logic [32*NUM_REGS-1:0]  cfg_q, cfg_d;
  logic                    verify_q, verify_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic                    error_q, error_d;
  logic [1:0]              err_code_q, err_code_d;
  logic [3:0]              err_index_q, err_index_d;

  logic [31:0]             cur_word;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic                    aw_hs;
  logic                    w_hs;
  logic                    timeout;

  assign cur_word = cfg_q[32*idx_q +: 32];
  assign cur_addr = ADDR_WIDTH'(BASE_ADDR + 4 * int'(idx_q));

  // VALIDs are decoded from state so a reset or abort drops them immediately
  assign M_AXI_AWVALID = (state_q == WR_REQ) && !aw_done_q;
  assign M_AXI_WVALID  = (state_q == WR_REQ) && !w_done_q;
  assign M_AXI_BREADY  = (state_q == WR_RESP);
  assign M_AXI_ARVALID = (state_q == RD_REQ);
  assign M_AXI_RREADY  = (state_q == RD_DATA);
  assign M_AXI_AWADDR  = cur_addr;
  assign M_AXI_ARADDR  = cur_addr;
  assign M_AXI_WDATA   = cur_word;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_WSTRB   = 4'hF;

  assign busy      = (state_q != IDLE) && (state_q != FINISH);
  assign done      = (state_q == FINISH);
  assign error     = error_q;
  assign err_code  = err_code_q;
  assign err_index = err_index_q;

  assign aw_hs   = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs    = M_AXI_WVALID && M_AXI_WREADY;
  assign timeout = (tmo_q == TMO_LAST);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cfg_d       = cfg_q;
    verify_d    = verify_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    tmo_d       = tmo_q + TW'(1);
    error_d     = error_q;
    err_code_d  = err_code_q;
    err_index_d = err_index_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          cfg_d       = cfg_data;
          verify_d    = verify_en;
          idx_d       = 4'd0;
          error_d     = 1'b0;
          err_code_d  = 2'd0;
          err_index_d = 4'd0;
          state_d     = WR_REQ;
        end
      end
      WR_REQ: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          state_d = WR_RESP;
        end else if (timeout) begin
          error_d     = 1'b1;
          err_code_d  = 2'd3;
          err_index_d = idx_q;
          state_d     = FINISH;
        end
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != 2'b00) begin
            error_d     = 1'b1;
            err_code_d  = 2'd1;
            err_index_d = idx_q;
            state_d     = FINISH;
          end else if (idx_q == LAST_IDX) begin
            idx_d   = 4'd0;
            state_d = verify_q ? RD_REQ : FINISH;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = WR_REQ;
          end
        end else if (timeout) begin
          error_d     = 1'b1;
          err_code_d  = 2'd3;
          err_index_d = idx_q;
          state_d     = FINISH;
        end
      end
      RD_REQ: begin
        if (M_AXI_ARREADY) begin
          state_d = RD_DATA;
        end else if (timeout) begin
          error_d     = 1'b1;
          err_code_d  = 2'd3;
          err_index_d = idx_q;
          state_d     = FINISH;
        end
      end
      RD_DATA: begin
        if (M_AXI_RVALID) begin
          if (M_AXI_RRESP != 2'b00) begin
            error_d     = 1'b1;
            err_code_d  = 2'd1;
            err_index_d = idx_q;
            state_d     = FINISH;
          end else if (M_AXI_RDATA != cur_word) begin
            error_d     = 1'b1;
            err_code_d  = 2'd2;
            err_index_d = idx_q;
            state_d     = FINISH;
          end else if (idx_q == LAST_IDX) begin
            state_d = FINISH;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = RD_REQ;
          end
        end else if (timeout) begin
          error_d     = 1'b1;
          err_code_d  = 2'd3;
          err_index_d = idx_q;
          state_d     = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Every state entry restarts the wait budget and the per-write handshake flags
    if (state_d != state_q || state_q == IDLE || state_q == FINISH) begin
      tmo_d = '0;
    end
    if (state_d == WR_REQ && state_q != WR_REQ) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      cfg_q       <= '0;
      verify_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      tmo_q       <= '0;
      error_q     <= 1'b0;
      err_code_q  <= 2'd0;
      err_index_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cfg_q       <= cfg_d;
      verify_q    <= verify_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      tmo_q       <= tmo_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      err_index_q <= err_index_d;
    end
  end

endmodule

// File: tb/tb_tx_cfg_sequencer.sv
// Directed bench for tx_cfg_sequencer with a small AXI4-Lite slave model
// whose delays, error responses and corrupted reads are steered per test.
module tb_tx_cfg_sequencer;

  logic         clock;
  logic         reset;
  logic         start;
  logic         verifyEn;
  logic [127:0] cfgData;
  logic         busy, done, error;
  logic [1:0]   errCode;
  logic [3:0]   errIndex;
  logic [3:0]   awAddr, arAddr;
  logic [2:0]   awProt, arProt;
  logic         awValid, awReady, wValid, wReady;
  logic [31:0]  wData, rData;
  logic [3:0]   wStrb;
  logic [1:0]   bResp, rResp;
  logic         bValid, bReady, arValid, arReady, rValid, rReady;

  int errors = 0;
  int checks = 0;

  int wDelay = 0;
  int skewReg = -1;
  int bErrAddr = -1;
  int rCorruptAddr = -1;
  bit arBlock = 1'b0;

  logic        awHave, wHave;
  logic [3:0]  awAddrLat;
  logic [31:0] wDataLat;
  int          wWait;
  int          bCount;
  logic [31:0] mem [4];
  int          wrCnt [4];
  int          rdCnt [4];
  int          doneCount, awLowWHigh, arHigh;
  int          curWDelay;
  bit          gotDone;

  tx_cfg_sequencer #(
    .NUM_REGS(4), .ADDR_WIDTH(4), .BASE_ADDR(0), .TIMEOUT_CYCLES(16)
  ) dut (
    .ACLK(clock), .ARESET(reset), .start(start), .verify_en(verifyEn),
    .cfg_data(cfgData), .busy(busy), .done(done), .error(error),
    .err_code(errCode), .err_index(errIndex),
    .M_AXI_AWADDR(awAddr), .M_AXI_AWPROT(awProt), .M_AXI_AWVALID(awValid),
    .M_AXI_AWREADY(awReady), .M_AXI_WDATA(wData), .M_AXI_WSTRB(wStrb),
    .M_AXI_WVALID(wValid), .M_AXI_WREADY(wReady), .M_AXI_BRESP(bResp),
    .M_AXI_BVALID(bValid), .M_AXI_BREADY(bReady), .M_AXI_ARADDR(arAddr),
    .M_AXI_ARPROT(arProt), .M_AXI_ARVALID(arValid), .M_AXI_ARREADY(arReady),
    .M_AXI_RDATA(rData), .M_AXI_RRESP(rResp), .M_AXI_RVALID(rValid),
    .M_AXI_RREADY(rReady)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Slave readies are combinational on VALID; W can be held off on one chosen write
  assign curWDelay = (bCount == skewReg) ? wDelay : 0;
  assign awReady   = awValid;
  assign wReady    = wValid && (wWait >= curWDelay);
  assign arReady   = arValid && !arBlock;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      bValid    <= 1'b0;
      bResp     <= 2'b00;
      rValid    <= 1'b0;
      rResp     <= 2'b00;
      rData     <= 32'h0;
      awHave    <= 1'b0;
      wHave     <= 1'b0;
      awAddrLat <= 4'h0;
      wDataLat  <= 32'h0;
      wWait     <= 0;
      bCount    <= 0;
      for (int i = 0; i < 4; i++) begin
        mem[i]   <= 32'h0;
        wrCnt[i] <= 0;
        rdCnt[i] <= 0;
      end
    end else begin : slaveSeq
      logic        awH, wH;
      logic [3:0]  aA;
      logic [31:0] wD;
      awH = awHave;
      wH  = wHave;
      aA  = awAddrLat;
      wD  = wDataLat;
      if (awValid && awReady) begin
        awH = 1'b1;
        aA  = awAddr;
      end
      if (wValid && wReady) begin
        wH = 1'b1;
        wD = wData;
        wWait <= 0;
      end else if (wValid) begin
        wWait <= wWait + 1;
      end else begin
        wWait <= 0;
      end
      if (bValid && bReady) bValid <= 1'b0;
      if (awH && wH && !bValid) begin
        mem[aA[3:2]]   <= wD;
        wrCnt[aA[3:2]] <= wrCnt[aA[3:2]] + 1;
        bValid <= 1'b1;
        bResp  <= (int'(aA) == bErrAddr) ? 2'b10 : 2'b00;
        bCount <= bCount + 1;
        awH = 1'b0;
        wH  = 1'b0;
      end
      awHave    <= awH;
      wHave     <= wH;
      awAddrLat <= aA;
      wDataLat  <= wD;
      if (rValid && rReady) rValid <= 1'b0;
      if (arValid && arReady) begin
        rValid <= 1'b1;
        rResp  <= 2'b00;
        rData  <= (int'(arAddr) == rCorruptAddr) ? 32'hDEADBEEF : mem[arAddr[3:2]];
        rdCnt[arAddr[3:2]] <= rdCnt[arAddr[3:2]] + 1;
      end
    end
  end

  always @(negedge clock or posedge reset) begin
    if (reset) begin
      doneCount  <= 0;
      awLowWHigh <= 0;
      arHigh     <= 0;
    end else begin
      if (done) doneCount <= doneCount + 1;
      if (!awValid && wValid) awLowWHigh <= awLowWHigh + 1;
      if (arValid) arHigh <= arHigh + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyReset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic applyStimulus(input bit ver, input logic [127:0] cfg);
    @(negedge clock);
    verifyEn = ver;
    cfgData  = cfg;
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    gotDone = 1'b0;
    for (int i = 0; i < 400 && !gotDone; i++) begin
      @(negedge clock);
      if (done) gotDone = 1'b1;
    end
    checkOutput(tag, 32'(gotDone), 32'd1);
  endtask

  function automatic logic [127:0] packWords(input logic [31:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    verifyEn = 1'b0;
    cfgData  = '0;
    repeat (2) @(negedge clock);

    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst done", 32'(done), 32'd0);
    checkOutput("rst error", 32'(error), 32'd0);
    checkOutput("rst errCode", 32'(errCode), 32'd0);
    checkOutput("rst errIndex", 32'(errIndex), 32'd0);
    checkOutput("rst valids", {29'd0, awValid, wValid, arValid}, 32'd0);
    checkOutput("rst readies", {30'd0, bReady, rReady}, 32'd0);
    checkOutput("wstrb", 32'(wStrb), 32'hF);
    checkOutput("prot", {26'd0, awProt, arProt}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Basic program and verify
    applyStimulus(1'b1, packWords(32'd1, 32'd2, 32'd3, 32'd4));
    checkOutput("basic busy", 32'(busy), 32'd1);
    waitDone("basic done");
    checkOutput("basic error", 32'(error), 32'd0);
    checkOutput("basic errCode", 32'(errCode), 32'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("basic mem%0d", i), mem[i], 32'(i + 1));
      checkOutput($sformatf("basic wrCnt%0d", i), 32'(wrCnt[i]), 32'd1);
      checkOutput($sformatf("basic rdCnt%0d", i), 32'(rdCnt[i]), 32'd1);
    end
    @(negedge clock);
    checkOutput("basic doneCount", 32'(doneCount), 32'd1);
    checkOutput("basic idle busy", 32'(busy), 32'd0);

    // W held off for five cycles on register 1 while AW completes at once
    applyReset();
    wDelay  = 5;
    skewReg = 1;
    applyStimulus(1'b1, packWords(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444));
    waitDone("skew done");
    checkOutput("skew error", 32'(error), 32'd0);
    checkOutput("skew awLowWHigh", 32'(awLowWHigh), 32'd5);
    checkOutput("skew mem1", mem[1], 32'h22222222);
    checkOutput("skew mem3", mem[3], 32'h44444444);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("skew wrCnt%0d", i), 32'(wrCnt[i]), 32'd1);
    wDelay  = 0;
    skewReg = -1;

    // Slave error on the write to 0x8
    applyReset();
    bErrAddr = 8;
    applyStimulus(1'b1, packWords(32'hA, 32'hB, 32'hC, 32'hD));
    waitDone("werr done");
    checkOutput("werr error", 32'(error), 32'd1);
    checkOutput("werr errCode", 32'(errCode), 32'd1);
    checkOutput("werr errIndex", 32'(errIndex), 32'd2);
    checkOutput("werr wrCnt3", 32'(wrCnt[3]), 32'd0);
    checkOutput("werr rdCnt0", 32'(rdCnt[0]), 32'd0);
    repeat (3) @(negedge clock);
    checkOutput("werr sticky", 32'(error), 32'd1);
    checkOutput("werr doneCount", 32'(doneCount), 32'd1);
    bErrAddr = -1;
    applyStimulus(1'b0, packWords(32'h5, 32'h6, 32'h7, 32'h8));
    checkOutput("restart clears error", 32'(error), 32'd0);
    checkOutput("restart clears errCode", 32'(errCode), 32'd0);
    waitDone("restart done");
    checkOutput("restart error", 32'(error), 32'd0);
    checkOutput("restart mem2", mem[2], 32'h7);

    // Corrupted readback at 0x4
    applyReset();
    rCorruptAddr = 4;
    applyStimulus(1'b1, packWords(32'h100, 32'h200, 32'h300, 32'h400));
    waitDone("mism done");
    checkOutput("mism error", 32'(error), 32'd1);
    checkOutput("mism errCode", 32'(errCode), 32'd2);
    checkOutput("mism errIndex", 32'(errIndex), 32'd1);
    checkOutput("mism rdCnt1", 32'(rdCnt[1]), 32'd1);
    checkOutput("mism rdCnt2", 32'(rdCnt[2]), 32'd0);
    rCorruptAddr = -1;

    // ARREADY never comes
    applyReset();
    arBlock = 1'b1;
    applyStimulus(1'b1, packWords(32'h1, 32'h2, 32'h3, 32'h4));
    waitDone("tmo done");
    checkOutput("tmo arHigh", 32'(arHigh), 32'd16);
    checkOutput("tmo error", 32'(error), 32'd1);
    checkOutput("tmo errCode", 32'(errCode), 32'd3);
    checkOutput("tmo errIndex", 32'(errIndex), 32'd0);
    checkOutput("tmo arValid", 32'(arValid), 32'd0);
    arBlock = 1'b0;

    // A second start while busy must be ignored
    applyReset();
    applyStimulus(1'b1, packWords(32'hAA, 32'hBB, 32'hCC, 32'hDD));
    repeat (3) @(negedge clock);
    cfgData = packWords(32'h1, 32'h2, 32'h3, 32'h4);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    waitDone("busy-start done");
    checkOutput("busy-start mem0", mem[0], 32'hAA);
    checkOutput("busy-start mem3", mem[3], 32'hDD);
    checkOutput("busy-start wrCnt0", 32'(wrCnt[0]), 32'd1);
    repeat (10) @(negedge clock);
    checkOutput("busy-start no restart", 32'(busy), 32'd0);
    checkOutput("busy-start doneCount", 32'(doneCount), 32'd1);

    // Reset asserted while the write response is being accepted
    applyReset();
    applyStimulus(1'b1, packWords(32'h9, 32'h8, 32'h7, 32'h6));
    gotDone = 1'b0;
    for (int i = 0; i < 50 && !gotDone; i++) begin
      if (bReady) gotDone = 1'b1;
      else @(negedge clock);
    end
    checkOutput("midrst saw WR_RESP", 32'(gotDone), 32'd1);
    #1 reset = 1'b1;
    #1;
    checkOutput("midrst valids", {29'd0, awValid, wValid, arValid}, 32'd0);
    checkOutput("midrst bReady", 32'(bReady), 32'd0);
    checkOutput("midrst busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    checkOutput("midrst no done", 32'(doneCount), 32'd0);
    checkOutput("midrst idle", 32'(busy), 32'd0);
    applyStimulus(1'b1, packWords(32'h12, 32'h34, 32'h56, 32'h78));
    waitDone("post-rst done");
    checkOutput("post-rst error", 32'(error), 32'd0);
    checkOutput("post-rst mem0", mem[0], 32'h12);
    checkOutput("post-rst mem3", mem[3], 32'h78);
    checkOutput("post-rst rdCnt3", 32'(rdCnt[3]), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
